itcm_ctrl: RTL and testbench
============================

// Module: itcm_ctrl
// PURPOSE
//  Instruction tightly-coupled memory controller. Sits directly upstream of ifu.
//  Takes pc_to_itcm/ifu_to_itcm_req and returns itcm_inst/itcm_ready one cycle later,
//  which lines up with ifu's registered pc_present.
//  Also provides a secondary loader/debug port for program load and readback while the core is halted.
//  Owns a synchronous single-port SRAM (sub-module itcm_sram) and the arbitration between the two ports.
// PARAMETERS
//  ITCM_AW    14             word-address width; ITCM size = 4*2^ITCM_AW bytes (64 KiB)
//  ITCM_BASE  32'h8000_0000  byte base address of the ITCM region
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  ifu_req      in   1   fetch request (ifu_to_itcm_req)
//  ifu_addr     in   32  fetch byte address (pc_to_itcm)
//  itcm_ready   out  1   fetch response valid; refers to the request of the previous cycle
//  itcm_inst    out  32  fetched instruction; 0 when itcm_ready=0 or itcm_err=1
//  itcm_err     out  1   fetch response is a fault (out of range or misaligned)
//  core_halt    in   1   core halted; loader port may preempt fetch
//  ext_req      in   1   loader access request
//  ext_we       in   1   1=write, 0=read
//  ext_addr     in   32  loader byte address
//  ext_wdata    in   32  write data
//  ext_wstrb    in   4   byte write enables
//  ext_gnt      out  1   loader access accepted this cycle (combinational)
//  ext_rvalid   out  1   loader read/write response valid (one cycle after ext_gnt)
//  ext_rdata    out  32  loader read data; 0 for writes and errors
//  ext_err      out  1   loader access out of range or misaligned
// BEHAVIOUR
//  Address decode
//  - An address is in range when (addr - ITCM_BASE) < 4<<ITCM_AW, using unsigned 32-bit compare.
//  - An address is aligned when addr[1:0]==0.
//  - SRAM word index = (addr - ITCM_BASE) >> 2, truncated to ITCM_AW bits.
//  Arbitration
//  - ext_gnt = ext_req & (core_halt | ~ifu_req).
//  - A granted ext access owns the SRAM for that cycle. Otherwise a valid ifu request owns it.
//  - There is one SRAM access per cycle. There is no back-pressure on ifu.
//  FSM (the response owner for the next cycle; registered)
//  - S_IDLE: no response pending.
//  - S_IFU: an in-range, aligned fetch was issued.
//  - S_IFU_ERR: a bad fetch was accepted; the SRAM is not accessed.
//  - S_EXT: a loader access was granted.
//  - Next state is computed every cycle from the request inputs, so any state can go to any state.
//  - Priority: ext grant, then ifu_req, then idle.
//  Responses (all one cycle after issue)
//  - S_IFU: itcm_ready=1, itcm_inst=mem[idx], itcm_err=0.
//  - S_IFU_ERR: itcm_ready=1, itcm_inst=0, itcm_err=1.
//  - S_EXT: ext_rvalid=1, ext_rdata = read ? mem[idx] : 0, ext_err as decoded.
//    itcm_ready=0 in the same cycle.
//  - S_IDLE: itcm_ready=0, ext_rvalid=0, all data outputs 0.
//  - Consecutive fetches to the same address (ifu stall) each cost one SRAM read and return identical data.
//  Writes
//  - A write happens in the grant cycle; bytes are written per ext_wstrb.
//  - A bad-address write is dropped but still responds with ext_err=1.
//  Read-after-write
//  - A read in the cycle after a write to the same word returns the new data.
//    The SRAM is write-first, or a bypass register provides the same result.
//  Reset
//  - All outputs 0 and FSM in S_IDLE. SRAM contents are not reset.
//  - An in-flight response is discarded on reset and never appears after rst_n deasserts.
//  - The first fetch response can come no earlier than the second clk edge after rst_n rises.
// STRUCTURE
//  - defines.v: add ZCRV_ITCM_BASE, ZCRV_ITCM_AW, and the FSM state localparams (2-bit encoding).
//  - Sub-module itcm_sram: sync single-port, depth 2^ITCM_AW x 32, 4 byte enables, 1-cycle read, write-first.
//  - itcm_ctrl contains the decode, arbitration, FSM and output muxing.
// TESTING
//  1. Preload mem[0]=32'h0000_0013 and mem[1]=32'h0010_0093. Fetch 0x8000_0000, then 0x8000_0004 back-to-back
//     -> ready=1 with inst 0x0000_0013 at t+1, then 0x0010_0093 at t+2, err=0.
//  2. Fetch 0x7FFF_FFFC (reset PC) and 0x8001_0000
//     -> each returns ready=1, inst=0, err=1 one cycle later; SRAM is not accessed.
//  3. Fetch 0x8000_0002 -> ready=1, inst=0, err=1.
//  4. core_halt=1, ifu_req=1. Write 0xDEAD_BEEF with wstrb 4'b0011 to 0x8000_0008 (old value 0),
//     then read it back -> ext_gnt=1 both cycles, readback 0x0000_BEEF, itcm_ready=0 in both response cycles.
//  5. core_halt=0, ifu_req=1, ext_req=1 for 10 cycles -> ext_gnt=0 throughout and fetches are unaffected.
//     Then drop ifu_req -> ext_gnt=1 in that cycle.
//  6. Assert rst_n low the cycle after a fetch to 0x8000_0000 -> itcm_ready, itcm_inst and FSM go to 0/S_IDLE
//     immediately (asynchronous), and no stale response appears after release.

Source files
------------

// File: rtl/itcm_ctrl_pkg.sv
// itcm_ctrl_pkg
//  Shared definitions for the instruction TCM controller: default region
//  geometry, the response-owner FSM encoding and the address-check helper.
package itcm_ctrl_pkg;

    localparam int          ZCRV_ITCM_AW   = 14;
    localparam logic [31:0] ZCRV_ITCM_BASE = 32'h8000_0000;

    // Response owner for the following cycle.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IFU     = 2'd1,
        S_IFU_ERR = 2'd2,
        S_EXT     = 2'd3
    } itcm_state_e;

    // True when addr lies inside [base, base + 4<<aw) and is word aligned.
    // The subtraction wraps, so addresses below base become huge and fail
    // the single unsigned compare. The size is held in 33 bits so that a
    // region covering the whole 4 GiB space still compares correctly.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          aw);
        logic [31:0] off;
        logic [32:0] size;
        off  = addr - base;
        size = 33'd4 << aw;
        return ({1'b0, off} < size) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/itcm_ctrl_sram.sv
// itcm_sram
//  Synchronous single-port SRAM, 2^AW x 32, four byte-write enables,
//  one-cycle registered read, write-first (a written lane returns the new
//  byte on the same access). Contents are not reset.
// Ports
//  clk    clock
//  en     access enable (read or write)
//  we     write enable, qualified per lane by wstrb
//  addr   word address
//  wdata  write data
//  wstrb  byte write enables
//  rdata  read data, valid the cycle after an enabled access
module itcm_sram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    // One 8-bit wide array per byte lane keeps each lane a plain
    // single-port RAM with its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we && wstrb[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                    rdata_reg <= wdata[gi*8 +: 8];
                end else begin
                    rdata_reg <= mem[addr];
                end
            end
        end

        assign rdata[gi*8 +: 8] = rdata_reg;
    end

endmodule

// File: rtl/itcm_ctrl.sv
// itcm_ctrl
//  Instruction TCM controller. Serves ifu fetches with a one-cycle response
//  and a loader/debug port that may take the SRAM whenever the core is
//  halted or the ifu is not requesting. One SRAM access per cycle; ifu is
//  never stalled.
// Ports
//  clk, rst_n                    clock, asynchronous active-low reset
//  ifu_req, ifu_addr             fetch request and byte address
//  itcm_ready/inst/err           fetch response for the previous cycle
//  core_halt                     lets the loader preempt fetch
//  ext_req/we/addr/wdata/wstrb   loader access
//  ext_gnt                       loader access accepted this cycle
//  ext_rvalid/rdata/err          loader response, one cycle after ext_gnt
module itcm_ctrl
    import itcm_ctrl_pkg::*;
#(
    parameter int          ITCM_AW   = ZCRV_ITCM_AW,
    parameter logic [31:0] ITCM_BASE = ZCRV_ITCM_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        itcm_ready,
    output logic [31:0] itcm_inst,
    output logic        itcm_err,
    input  logic        core_halt,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [3:0]  ext_wstrb,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic        ext_err
);

    logic               ifu_ok;
    logic               ext_ok;
    logic [ITCM_AW-1:0] ifu_idx;
    logic [ITCM_AW-1:0] ext_idx;
    logic               sram_en;
    logic               sram_we;
    logic [ITCM_AW-1:0] sram_addr;
    logic [31:0]        sram_rdata;

    itcm_state_e        state_reg;
    logic               ext_err_reg;
    logic               ext_we_reg;

    // Address decode
    assign ifu_ok  = addr_ok(ifu_addr, ITCM_BASE, ITCM_AW);
    assign ext_ok  = addr_ok(ext_addr, ITCM_BASE, ITCM_AW);
    assign ifu_idx = ITCM_AW'((ifu_addr - ITCM_BASE) >> 2);
    assign ext_idx = ITCM_AW'((ext_addr - ITCM_BASE) >> 2);

    // Arbitration: a granted loader access owns the SRAM, otherwise a valid
    // fetch does. Bad addresses never touch the array, so a bad write is
    // dropped here.
    assign ext_gnt   = ext_req & (core_halt | ~ifu_req);
    assign sram_en   = ext_gnt ? ext_ok : (ifu_req & ifu_ok);
    assign sram_we   = ext_gnt & ext_we & ext_ok;
    assign sram_addr = ext_gnt ? ext_idx : ifu_idx;

    itcm_sram #(
        .AW (ITCM_AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (ext_wdata),
        .wstrb (ext_wstrb),
        .rdata (sram_rdata)
    );

    // Response-owner FSM. Next state depends only on this cycle's requests,
    // so every state can follow every other. Loader grant wins, then fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            ext_err_reg <= 1'b0;
            ext_we_reg  <= 1'b0;
        end else begin
            ext_err_reg <= 1'b0;
            ext_we_reg  <= 1'b0;
            if (ext_gnt) begin
                state_reg   <= S_EXT;
                ext_err_reg <= ~ext_ok;
                ext_we_reg  <= ext_we;
            end else if (ifu_req) begin
                state_reg <= ifu_ok ? S_IFU : S_IFU_ERR;
            end else begin
                state_reg <= S_IDLE;
            end
        end
    end

    // Output muxing. Everything is gated by the registered state, so the
    // unreset SRAM read register can never leak through after reset.
    assign itcm_ready = (state_reg == S_IFU) || (state_reg == S_IFU_ERR);
    assign itcm_err   = (state_reg == S_IFU_ERR);
    assign itcm_inst  = (state_reg == S_IFU) ? sram_rdata : 32'h0;
    assign ext_rvalid = (state_reg == S_EXT);
    assign ext_err    = (state_reg == S_EXT) && ext_err_reg;
    assign ext_rdata  = ((state_reg == S_EXT) && !ext_we_reg && !ext_err_reg)
                        ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_itcm_ctrl.sv
// tb_itcm_ctrl
//  Self-checking bench for itcm_ctrl. A word-level memory model and the
//  arbitration/decode rules give the expected response of every cycle.
module tb_itcm_ctrl;

    localparam logic [31:0] BASE       = 32'h8000_0000;
    localparam int unsigned SIZE_BYTES = 32'd65536;
    localparam int unsigned LAST_WORD  = 16383;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        itcm_ready;
    logic [31:0] itcm_inst;
    logic        itcm_err;
    logic        core_halt = 1'b0;
    logic        ext_req = 1'b0;
    logic        ext_we = 1'b0;
    logic [31:0] ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic [3:0]  ext_wstrb = '0;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        ext_err;

    itcm_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ifu_req    (ifu_req),
        .ifu_addr   (ifu_addr),
        .itcm_ready (itcm_ready),
        .itcm_inst  (itcm_inst),
        .itcm_err   (itcm_err),
        .core_halt  (core_halt),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_wstrb  (ext_wstrb),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .ext_err    (ext_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        itcm_ready;
        logic [31:0] itcm_inst;
        logic        itcm_err;
        logic        ext_rvalid;
        logic [31:0] ext_rdata;
        logic        ext_err;
    } resp_t;

    logic [31:0] mdl_mem [int unsigned];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic resp_t observed();
        return '{itcm_ready, itcm_inst, itcm_err, ext_rvalid, ext_rdata, ext_err};
    endfunction

    function automatic bit good(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < SIZE_BYTES) && (a % 4 == 0);
    endfunction

    task automatic drive(input logic ir, input logic [31:0] ia, input logic h,
                         input logic er, input logic we, input logic [31:0] ea,
                         input logic [31:0] wd, input logic [3:0] ws);
        ifu_req   = ir;
        ifu_addr  = ia;
        core_halt = h;
        ext_req   = er;
        ext_we    = we;
        ext_addr  = ea;
        ext_wdata = wd;
        ext_wstrb = ws;
    endtask

    // Reference: what the currently driven inputs must produce next cycle.
    task automatic model_issue(output resp_t exp, output logic exp_gnt);
        int unsigned w;
        logic [31:0] tmp;
        exp     = '0;
        exp_gnt = ext_req && (core_halt || !ifu_req);
        if (exp_gnt) begin
            exp.ext_rvalid = 1'b1;
            if (!good(ext_addr)) begin
                exp.ext_err = 1'b1;
            end else begin
                w = (ext_addr - BASE) / 4;
                tmp = mdl_mem.exists(w) ? mdl_mem[w] : 32'hx;
                if (ext_we) begin
                    for (int b = 0; b < 4; b++)
                        if (ext_wstrb[b]) tmp[8*b +: 8] = ext_wdata[8*b +: 8];
                    mdl_mem[w] = tmp;
                end else begin
                    exp.ext_rdata = tmp;
                end
            end
        end else if (ifu_req) begin
            exp.itcm_ready = 1'b1;
            if (good(ifu_addr)) exp.itcm_inst = mdl_mem[(ifu_addr - BASE) / 4];
            else                exp.itcm_err  = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k <= 6)      return BASE + 4 * $urandom_range(0, 15);
        else if (k == 7) return BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
        else if (k == 8) return BASE + 4 * LAST_WORD;
        else             return ($urandom_range(0, 1) == 1) ? BASE - 4
                                : BASE + SIZE_BYTES + 4 * $urandom_range(0, 100);
    endfunction

    task automatic test_reset();
        drive(1'b1, BASE, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (observed() !== '0)
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, observed());
            if (observed() !== '0) n_fail++;
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic preload();
        resp_t exp;
        logic  eg;
        for (int w = 0; w <= 16; w++) begin
            logic [31:0] d;
            int unsigned wi;
            wi = (w == 16) ? LAST_WORD : w;
            d  = (w == 0) ? 32'h0000_0013 : (w == 1) ? 32'h0010_0093 :
                 (w == 2) ? 32'h0 : $urandom();
            drive(1'b0, '0, 1'b1, 1'b1, 1'b1, BASE + 4 * wi, d, 4'hF);
            model_issue(exp, eg);
            @(posedge clk); #1;
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_basic();
        resp_t exp;
        logic  eg;
        logic [31:0] req_inst [2];
        req_inst[0] = 32'h0000_0013;
        req_inst[1] = 32'h0010_0093;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, BASE + 4 * i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            model_issue(exp, eg);
            @(posedge clk); #1;
            n_checks++;
            if (observed() !== exp || itcm_inst !== req_inst[i] || itcm_err !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_basic %0d: got %h expected %h (inst %h)", i, observed(), exp, req_inst[i]);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL fetch_idle: got %h expected 0", observed());
        end
    endtask

    task automatic test_fetch_errors();
        resp_t exp;
        logic  eg;
        logic [31:0] addrs [5];
        addrs = '{32'h7FFF_FFFC, 32'h8001_0000, 32'h8000_0002, 32'h8000_FFFC, 32'h8000_FFFE};
        foreach (addrs[i]) begin
            drive(1'b1, addrs[i], 1'b0, 1'b0, 1'b0, '0, '0, '0);
            model_issue(exp, eg);
            @(posedge clk); #1;
            n_checks++;
            if (observed() !== exp || itcm_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fetch_err addr %h: got %h expected %h", addrs[i], observed(), exp);
            end
        end
    endtask

    task automatic test_ext_write_read();
        resp_t exp;
        logic  eg;
        logic [31:0] ea [3];
        logic        wr [3];
        ea = '{32'h8000_0008, 32'h8000_0008, 32'h8001_0000};
        wr = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, BASE, 1'b1, 1'b1, wr[i], ea[i], 32'hDEAD_BEEF, 4'b0011);
            model_issue(exp, eg);
            #1;
            n_checks++;
            if (ext_gnt !== eg || eg !== 1'b1) begin
                n_fail++;
                $display("FAIL ext_gnt halted %0d: got %b expected 1", i, ext_gnt);
            end
            @(posedge clk); #1;
            n_checks++;
            if (observed() !== exp || itcm_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ext_rw %0d: got %h expected %h", i, observed(), exp);
            end
            if (i == 1) begin
                n_checks++;
                if (ext_rdata !== 32'h0000_BEEF) begin
                    n_fail++;
                    $display("FAIL ext_readback: got %h expected 0000beef", ext_rdata);
                end
            end
        end
    endtask

    task automatic test_ext_blocked();
        resp_t exp;
        logic  eg;
        for (int i = 0; i < 11; i++) begin
            if (i < 10) drive(1'b1, BASE + 4 * (i % 16), 1'b0, 1'b1, 1'b1, BASE, $urandom(), 4'hF);
            else        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, BASE, '0, '0);
            model_issue(exp, eg);
            #1;
            n_checks++;
            if (ext_gnt !== eg || ext_gnt !== (i == 10)) begin
                n_fail++;
                $display("FAIL ext_blocked_gnt %0d: got %b expected %b", i, ext_gnt, eg);
            end
            @(posedge clk); #1;
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL ext_blocked_resp %0d: got %h expected %h", i, observed(), exp);
            end
        end
    endtask

    task automatic test_random();
        resp_t exp;
        logic  eg;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), rand_addr(), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 1), rand_addr(),
                  $urandom(), 4'($urandom()));
            model_issue(exp, eg);
            #1;
            n_checks++;
            if (ext_gnt !== eg) begin
                n_fail++;
                $display("FAIL rand_gnt %0d: got %b expected %b", i, ext_gnt, eg);
            end
            @(posedge clk); #1;
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL rand_resp %0d: got %h expected %h", i, observed(), exp);
            end
        end
    endtask

    task automatic test_reset_inflight();
        resp_t exp;
        logic  eg;
        drive(1'b1, BASE, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        model_issue(exp, eg);
        @(posedge clk); #1;
        n_checks++;
        if (observed() !== exp || itcm_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_pre: got %h expected %h", observed(), exp);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", observed());
        end
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (observed() !== '0) begin
                n_fail++;
                $display("FAIL stale_after_reset %0d: got %h expected 0", i, observed());
            end
        end
        drive(1'b1, BASE + 4, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        model_issue(exp, eg);
        @(posedge clk); #1;
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL fetch_after_reset: got %h expected %h", observed(), exp);
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_fetch_basic();
        test_fetch_errors();
        test_ext_write_read();
        test_ext_blocked();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
